// File: rtl/scan_reg_chain_pkg.sv
// Shared constants for the scan register chain: word length and scan FSM encodings.
package scan_reg_chain_pkg;

    localparam int WORD_LENGTH = 32;

    localparam logic [1:0] SCAN_IDLE  = 2'd0;
    localparam logic [1:0] SCAN_SHIFT = 2'd1;
    localparam logic [1:0] SCAN_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = SCAN_IDLE,
        ST_SHIFT = SCAN_SHIFT,
        ST_DONE  = SCAN_DONE
    } scan_state_t;

endpackage

// File: rtl/scan_reg_cell.sv
// One chain register: sync reset, parallel load, and a 1-bit shift toward bit 0 (the MSB).
module scan_reg_cell #(
    parameter int                 WIDTH     = 32,
    parameter logic [0:WIDTH-1]   RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [0:WIDTH-1]     d,
    input  logic                 shift,
    input  logic                 ser_in,
    output logic                 ser_out,
    output logic [0:WIDTH-1]     value
);

    logic [0:WIDTH-1] r;
    logic [0:WIDTH]   shifted;

    // Appending ser_in and dropping bit 0 keeps WIDTH==1 legal.
    assign shifted = {r, ser_in};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= RESET_VAL;
        end else if (load) begin
            r <= d;
        end else if (shift) begin
            r <= shifted[1:WIDTH];
        end
    end

    assign ser_out = r[0];
    assign value   = r;

endmodule

// File: rtl/scan_reg_chain.sv
// Bank of DEPTH registers with parallel write/read and a serial scan controller (MSB of reg 0 first).
module scan_reg_chain
    import scan_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = WORD_LENGTH,
    parameter int               DEPTH     = 4,
    parameter logic [0:WIDTH-1] RESET_VAL = '0,
    localparam int              SEL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [0:WIDTH-1]    d,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [0:WIDTH-1]    q,
    input  logic                scan_start,
    input  logic                scan_hold,
    input  logic                scan_in,
    output logic                scan_out,
    output logic                scan_busy,
    output logic                scan_done
);

    localparam int               N      = WIDTH * DEPTH;
    localparam int               CNT_W  = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N);
    localparam logic [SEL_W:0]   DEPTH_L = (SEL_W + 1)'(DEPTH);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             shift_en;
    logic [DEPTH:0]   link;
    logic [0:WIDTH-1] regs [DEPTH];

    // Shifting stops once cnt hits N; that cycle is spent moving to DONE.
    assign shift_en = (state == ST_SHIFT) && !scan_hold && (cnt != N_CNT);
    assign link[DEPTH] = scan_in;
    assign scan_out = link[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        scan_reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .load    ((state == ST_IDLE) && wr_en && (wr_sel == SEL_W'(i))),
            .d       (d),
            .shift   (shift_en),
            .ser_in  (link[i+1]),
            .ser_out (link[i]),
            .value   (regs[i])
        );
    end

    always_comb begin
        q = RESET_VAL;
        if ({1'b0, rd_sel} < DEPTH_L) begin
            q = regs[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    scan_done <= 1'b0;
                    if (scan_start) begin
                        state     <= ST_SHIFT;
                        scan_busy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == N_CNT) begin
                        state     <= ST_DONE;
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                    end else if (!scan_hold) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    scan_done <= 1'b0;
                    cnt       <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    scan_busy <= 1'b0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_reg_chain.sv
// Directed bench for scan_reg_chain with WIDTH=8, DEPTH=2 (16-bit chain).
module tb_scan_reg_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       wr_sel;
    logic [7:0] d;
    logic       rd_sel;
    logic [7:0] q;
    logic       scan_start;
    logic       scan_hold;
    logic       scan_in;
    logic       scan_out;
    logic       scan_busy;
    logic       scan_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_reg_chain #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .d          (d),
        .rd_sel     (rd_sel),
        .q          (q),
        .scan_start (scan_start),
        .scan_hold  (scan_hold),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic sel, input logic [7:0] exp, input string tag);
        rd_sel = sel;
        #1;
        check(tag, {24'd0, q}, {24'd0, exp});
    endtask

    // Runs one full scan; optional same-cycle write of 0x81 to reg 0 and an optional 3-cycle hold.
    task automatic do_scan(input logic [15:0] pat, input logic [15:0] exp_out, input bit pre_write,
                           input int hold_at, input int exp_cycles, input string tag);
        logic [15:0] got;
        logic        held;
        int          cycles;
        bit          seen;
        got = '0;
        scan_start = 1'b1;
        if (pre_write) begin
            wr_en  = 1'b1;
            wr_sel = 1'b0;
            d      = 8'h81;
        end
        step();
        scan_start = 1'b0;
        wr_en      = 1'b0;
        cycles     = 1;
        check({tag, "_busy_on"}, {31'd0, scan_busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == hold_at) begin
                scan_hold = 1'b1;
                wr_en     = 1'b1;
                wr_sel    = 1'b0;
                d         = 8'hFF;
                for (int h = 0; h < 3; h++) begin
                    held = scan_out;
                    step();
                    cycles++;
                    check({tag, "_hold_out"}, {31'd0, scan_out}, {31'd0, held});
                end
                scan_hold = 1'b0;
                wr_en     = 1'b0;
            end
            got[15-i] = scan_out;
            scan_in   = pat[15-i];
            step();
            cycles++;
        end
        scan_in = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (scan_done) seen = 1'b1;
            else begin
                step();
                cycles++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cycles, exp_cycles);
        check({tag, "_stream"}, {16'd0, got}, {16'd0, exp_out});
        check({tag, "_busy_off"}, {31'd0, scan_busy}, 32'd0);
        step();
        check({tag, "_done_pulse"}, {31'd0, scan_done}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        d          = 8'h00;
        rd_sel     = 1'b0;
        scan_start = 1'b0;
        scan_hold  = 1'b0;
        scan_in    = 1'b0;

        // Reset
        step();
        step();
        read_chk(1'b0, 8'h00, "rst_q0");
        read_chk(1'b1, 8'h00, "rst_q1");
        check("rst_busy", {31'd0, scan_busy}, 32'd0);
        check("rst_done", {31'd0, scan_done}, 32'd0);
        check("rst_out", {31'd0, scan_out}, 32'd0);
        rst = 1'b1;

        // Parallel write / read
        wr_en = 1'b1; wr_sel = 1'b0; d = 8'hA5;
        step();
        wr_sel = 1'b1; d = 8'h3C;
        step();
        wr_en = 1'b0;
        read_chk(1'b0, 8'hA5, "wr_q0");
        read_chk(1'b1, 8'h3C, "wr_q1");
        check("wr_out", {31'd0, scan_out}, 32'd1);

        // Full scan
        do_scan(16'hF00F, 16'hA53C, 1'b0, -1, 18, "scan1");
        read_chk(1'b0, 8'hF0, "scan1_q0");
        read_chk(1'b1, 8'h0F, "scan1_q1");

        // Hold for 3 cycles with an ignored write
        do_scan(16'hF00F, 16'hF00F, 1'b0, 5, 21, "hold");
        read_chk(1'b0, 8'hF0, "hold_q0");
        read_chk(1'b1, 8'h0F, "hold_q1");

        // Write and start in the same cycle
        do_scan(16'h1234, 16'h810F, 1'b1, -1, 18, "simul");
        read_chk(1'b0, 8'h12, "simul_q0");
        read_chk(1'b1, 8'h34, "simul_q1");

        // Reset after 7 shifts
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            scan_in = 1'b1;
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        scan_in = 1'b0;
        read_chk(1'b0, 8'h00, "abort_q0");
        read_chk(1'b1, 8'h00, "abort_q1");
        check("abort_busy", {31'd0, scan_busy}, 32'd0);
        check("abort_done", {31'd0, scan_done}, 32'd0);
        check("abort_out", {31'd0, scan_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", {31'd0, scan_done}, 32'd0);
            check("abort_idle_busy", {31'd0, scan_busy}, 32'd0);
        end
        do_scan(16'hBEEF, 16'h0000, 1'b0, -1, 18, "rescan");
        read_chk(1'b0, 8'hBE, "rescan_q0");
        read_chk(1'b1, 8'hEF, "rescan_q1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
